// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for an instruction-fetch and a load/store requester
// Ports: clk, rst_n (async, active-low)
//        i_req/i_addr -> i_gnt/i_rvalid/i_rdata/i_err   fetch requester (read-only)
//        d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt/d_rvalid/d_rdata/d_err   load/store requester
//        m_req/m_we/m_addr/m_wdata/m_wstrb <- m_gnt/m_rvalid/m_rdata   shared memory port
//        i_stall/d_stall   datapath freeze controls
module mem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int DATA_PRIORITY = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            i_stall,
    output logic            d_stall
);

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam int             CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // Port encoding for owner/lock/winner: 1 = data, 0 = fetch.
    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          lock_q, lock_d;
    logic          lock_own_q, lock_own_d;
    logic          rr_data_q, rr_data_d;   // 1 = data wins the next conflict
    logic [CW-1:0] cnt_q, cnt_d;

    logic win_d;
    logic any_req;
    logic lock_hold;
    logic to_hit;
    logic respond;

    // Winner selection. A locked winner is kept only while it still requests;
    // if it dropped its request, arbitration restarts in the same cycle.
    always_comb begin
        any_req   = i_req | d_req;
        lock_hold = lock_q & (lock_own_q ? d_req : i_req);
        if (lock_hold) begin
            win_d = lock_own_q;
        end else if (i_req && d_req) begin
            win_d = (DATA_PRIORITY != 0) ? 1'b1 : rr_data_q;
        end else begin
            win_d = d_req;
        end
        // Timeout fires in the BUSY cycle in which the count would reach TIMEOUT.
        to_hit  = TO_EN && (state_q == S_BUSY) && !m_rvalid && (cnt_q == CNT_LAST);
        respond = (state_q == S_BUSY) && (m_rvalid || to_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            rr_data_q  <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            rr_data_q  <= rr_data_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        rr_data_d  = rr_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!any_req) begin
                    lock_d = 1'b0;
                end else if (m_gnt) begin
                    state_d   = S_BUSY;
                    owner_d   = win_d;
                    rr_data_d = ~win_d;
                    cnt_d     = '0;
                    lock_d    = 1'b0;
                end else begin
                    lock_d     = 1'b1;
                    lock_own_d = win_d;
                end
            end
            S_BUSY: begin
                if (respond) begin
                    state_d = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Everything is forced to zero while reset is asserted, even the paths
    // that are purely combinational from the requester inputs.
    always_comb begin
        i_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        i_stall  = 1'b0;
        d_stall  = 1'b0;
        if (rst_n) begin
            if (state_q == S_IDLE && any_req) begin
                m_req   = 1'b1;
                m_we    = win_d & d_we;
                m_addr  = win_d ? d_addr : i_addr;
                m_wdata = (win_d && d_we) ? d_wdata : '0;
                m_wstrb = (win_d && d_we) ? d_wstrb : '0;
                i_gnt   = m_gnt & ~win_d;
                d_gnt   = m_gnt & win_d;
            end
            if (respond) begin
                if (owner_q) begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rvalid ? m_rdata : '0;
                    d_err    = ~m_rvalid;
                end else begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rvalid ? m_rdata : '0;
                    i_err    = ~m_rvalid;
                end
            end
            i_stall = i_req & ~i_rvalid;
            d_stall = (d_req | (state_q == S_BUSY && owner_q)) & ~d_rvalid;
        end
    end

`ifndef SYNTHESIS
    // A pending (not yet granted) request must keep its fields steady.
    a_i_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (i_req && !i_gnt && !(state_q == S_BUSY && !owner_q)) |=> (!i_req || $stable(i_addr)));
    a_d_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_gnt && !(state_q == S_BUSY && owner_q))
        |=> (!d_req || $stable({d_we, d_addr, d_wdata, d_wstrb})));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_p = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        m_gnt = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we, i_stall, d_stall;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    logic        p_i_gnt, p_i_rvalid, p_i_err, p_d_gnt, p_d_rvalid, p_d_err, p_m_req, p_m_we;
    logic        p_i_stall, p_d_stall;
    logic [31:0] p_i_rdata, p_d_rdata, p_m_addr, p_m_wdata;
    logic [3:0]  p_m_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .DATA_PRIORITY(0), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .i_stall(i_stall), .d_stall(d_stall)
    );

    mem_arbiter #(.AW(32), .DW(32), .DATA_PRIORITY(1), .TIMEOUT(4)) dut_p (
        .clk(clk), .rst_n(rst_n_p),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(p_i_gnt), .i_rvalid(p_i_rvalid), .i_rdata(p_i_rdata), .i_err(p_i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata), .d_err(p_d_err),
        .m_req(p_m_req), .m_we(p_m_we), .m_addr(p_m_addr), .m_wdata(p_m_wdata), .m_wstrb(p_m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .i_stall(p_i_stall), .d_stall(p_d_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
        #3;
        checks++; if ({m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err} !== 8'h00) begin failures++; $display("FAIL reset_ctrl: got %b want 00000000", {m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err}); end
        checks++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin failures++; $display("FAIL reset_mbus: got addr %h wdata %h wstrb %h want 0", m_addr, m_wdata, m_wstrb); end
        checks++; if ({i_stall, d_stall} !== 2'b00 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_stall_rdata: got stall %b i_rdata %h d_rdata %h want 0", {i_stall, d_stall}, i_rdata, d_rdata); end
        do_reset();
        #1;
        checks++; if (m_req !== 1'b0 || i_stall !== 1'b0 || d_stall !== 1'b0) begin failures++; $display("FAIL reset_idle: got m_req %b stalls %b%b want 0", m_req, i_stall, d_stall); end
    endtask

    task automatic test_fetch();
        do_reset();
        i_req = 1'b1; i_addr = 32'h40; m_gnt = 1'b1;
        #1;
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt: got i_gnt %b d_gnt %b want 1 0", i_gnt, d_gnt); end
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0 || m_wstrb !== 4'h0) begin failures++; $display("FAIL fetch_mreq: got req %b addr %h we %b wstrb %h want 1 40 0 0", m_req, m_addr, m_we, m_wstrb); end
        checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0: got %b want 1", i_stall); end
        for (int c = 1; c < 3; c++) begin
            tick();
            m_gnt = 1'b0; m_rdata = 32'h11111111;
            #1;
            checks++; if (i_stall !== 1'b1 || i_rvalid !== 1'b0 || i_rdata !== 32'h0 || m_req !== 1'b0) begin failures++; $display("FAIL fetch_wait_c%0d: got stall %b rvalid %b rdata %h m_req %b want 1 0 0 0", c, i_stall, i_rvalid, i_rdata, m_req); end
        end
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h00500093;
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093 || i_err !== 1'b0) begin failures++; $display("FAIL fetch_resp: got rvalid %b rdata %h err %b want 1 00500093 0", i_rvalid, i_rdata, i_err); end
        checks++; if (i_stall !== 1'b0 || i_gnt !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_c3_misc: got stall %b gnt %b d_rvalid %b want 0 0 0", i_stall, i_gnt, d_rvalid); end
        tick();
        clear_inputs();
        #1;
        checks++; if (m_req !== 1'b0 || i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin failures++; $display("FAIL fetch_after: got m_req %b rvalid %b rdata %h want 0 0 0", m_req, i_rvalid, i_rdata); end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_we = 1'b0;
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5A;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            #1;
            checks++; if ({d_gnt, i_gnt} !== {1'(k % 4 == 0), 1'(k % 4 == 2)}) begin failures++; $display("FAIL rr_gnt_c%0d: got d %b i %b want d %b i %b", k, d_gnt, i_gnt, 1'(k % 4 == 0), 1'(k % 4 == 2)); end
            checks++; if ({d_rvalid, i_rvalid} !== {1'(k % 4 == 1), 1'(k % 4 == 3)}) begin failures++; $display("FAIL rr_rvalid_c%0d: got d %b i %b want d %b i %b", k, d_rvalid, i_rvalid, 1'(k % 4 == 1), 1'(k % 4 == 3)); end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_priority();
        rst_n = 1'b0;
        clear_inputs();
        rst_n_p = 1'b0;
        tick();
        tick();
        rst_n_p = 1'b1;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_we = 1'b0;
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5A;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            #1;
            checks++; if ({p_d_gnt, p_i_gnt} !== {1'(k % 2 == 0), 1'b0}) begin failures++; $display("FAIL prio_gnt_c%0d: got d %b i %b want d %b i 0", k, p_d_gnt, p_i_gnt, 1'(k % 2 == 0)); end
            checks++; if (p_d_rvalid !== 1'(k % 2 == 1) || p_d_rdata !== ((k % 2 == 1) ? 32'h5A : 32'h0)) begin failures++; $display("FAIL prio_resp_c%0d: got rvalid %b rdata %h", k, p_d_rvalid, p_d_rdata); end
            checks++; if (p_m_req !== 1'(k % 2 == 0) || (k % 2 == 0 && p_m_addr !== 32'h20) || p_i_stall !== 1'b1 || p_d_stall !== 1'(k % 2 == 0)) begin failures++; $display("FAIL prio_bus_c%0d: got m_req %b addr %h stalls %b%b", k, p_m_req, p_m_addr, p_i_stall, p_d_stall); end
            checks++; if ({p_m_we, p_m_wstrb, p_m_wdata, p_i_rvalid, p_i_err, p_d_err, p_i_rdata} !== '0) begin failures++; $display("FAIL prio_quiet_c%0d: got we %b wstrb %h wdata %h i_rvalid %b errs %b%b i_rdata %h want 0", k, p_m_we, p_m_wstrb, p_m_wdata, p_i_rvalid, p_i_err, p_d_err, p_i_rdata); end
        end
        tick();
        clear_inputs();
        rst_n_p = 1'b0;
    endtask

    task automatic test_store();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011; m_gnt = 1'b1;
        #1;
        checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_wstrb !== 4'b0011 || m_wdata !== 32'hDEADBEEF || m_addr !== 32'h100) begin failures++; $display("FAIL store_issue: got gnt %b we %b wstrb %b wdata %h addr %h want 1 1 0011 DEADBEEF 100", d_gnt, m_we, m_wstrb, m_wdata, m_addr); end
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0; m_gnt = 1'b0; m_rdata = 32'hFFFFFFFF;
        #1;
        checks++; if (d_stall !== 1'b1 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin failures++; $display("FAIL store_busy: got stall %b rvalid %b rdata %h want 1 0 0", d_stall, d_rvalid, d_rdata); end
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || d_stall !== 1'b0 || i_rvalid !== 1'b0) begin failures++; $display("FAIL store_ack: got rvalid %b rdata %h err %b stall %b i_rvalid %b want 1 0 0 0 0", d_rvalid, d_rdata, d_err, d_stall, i_rvalid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        i_req = 1'b1; i_addr = 32'h80; m_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            if (c == 1) begin d_req = 1'b1; d_addr = 32'h200; end
            #1;
            checks++; if (m_req !== 1'b1 || m_addr !== 32'h80 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL lock_c%0d: got req %b addr %h gnt i %b d %b want 1 80 0 0", c, m_req, m_addr, i_gnt, d_gnt); end
        end
        tick();
        m_gnt = 1'b1;
        #1;
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_addr !== 32'h80) begin failures++; $display("FAIL lock_grant: got i %b d %b addr %h want 1 0 80", i_gnt, d_gnt, m_addr); end
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h00000013;
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h13 || d_gnt !== 1'b0 || m_req !== 1'b0 || d_stall !== 1'b1) begin failures++; $display("FAIL lock_resp: got rvalid %b rdata %h d_gnt %b m_req %b d_stall %b want 1 13 0 0 1", i_rvalid, i_rdata, d_gnt, m_req, d_stall); end
        tick();
        i_req = 1'b0; m_rvalid = 1'b0;
        #1;
        checks++; if (d_gnt !== 1'b1 || m_addr !== 32'h200 || i_gnt !== 1'b0) begin failures++; $display("FAIL lock_dgrant: got d %b addr %h i %b want 1 200 0", d_gnt, m_addr, i_gnt); end
        tick();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h77) begin failures++; $display("FAIL lock_dresp: got rvalid %b rdata %h want 1 77", d_rvalid, d_rdata); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        i_req = 1'b1; i_addr = 32'h44; m_gnt = 1'b1; m_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL to_gnt: got %b want 1", i_gnt); end
        for (int c = 1; c < 4; c++) begin
            tick();
            m_gnt = 1'b0;
            #1;
            checks++; if (i_rvalid !== 1'b0 || i_err !== 1'b0) begin failures++; $display("FAIL to_wait_c%0d: got rvalid %b err %b want 0 0", c, i_rvalid, i_err); end
        end
        tick();
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0 || d_rvalid !== 1'b0 || i_stall !== 1'b0) begin failures++; $display("FAIL to_fire: got rvalid %b err %b rdata %h d_rvalid %b stall %b want 1 1 0 0 0", i_rvalid, i_err, i_rdata, d_rvalid, i_stall); end
        tick();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hAAAA5555;
        #1;
        checks++; if ({i_rvalid, d_rvalid, i_err, d_err, m_req} !== 5'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL to_late: got rvalid %b%b err %b%b m_req %b rdata %h %h want 0", i_rvalid, d_rvalid, i_err, d_err, m_req, i_rdata, d_rdata); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        do_reset();
        i_req = 1'b1; i_addr = 32'h48; m_gnt = 1'b1;
        #1;
        checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL rb_gnt: got %b want 1", i_gnt); end
        tick();
        m_gnt = 1'b0;
        #1;
        checks++; if (i_stall !== 1'b1 || i_rvalid !== 1'b0) begin failures++; $display("FAIL rb_busy: got stall %b rvalid %b want 1 0", i_stall, i_rvalid); end
        #1;
        rst_n = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        checks++; if ({m_req, i_rvalid, i_stall, d_stall, i_gnt, i_err} !== 6'b0 || m_addr !== 32'h0 || i_rdata !== 32'h0) begin failures++; $display("FAIL rb_async: got m_req %b rvalid %b stalls %b%b gnt %b err %b addr %h rdata %h want 0", m_req, i_rvalid, i_stall, d_stall, i_gnt, i_err, m_addr, i_rdata); end
        i_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL rb_late: got rvalid %b%b m_req %b want 0 0 0", i_rvalid, d_rvalid, m_req); end
        tick();
        i_req = 1'b1; i_addr = 32'h4C; m_gnt = 1'b1; m_rvalid = 1'b0;
        #1;
        checks++; if (i_gnt !== 1'b1 || m_addr !== 32'h4C) begin failures++; $display("FAIL rb_regrant: got gnt %b addr %h want 1 4C", i_gnt, m_addr); end
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00A00113;
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00A00113 || i_err !== 1'b0) begin failures++; $display("FAIL rb_resp: got rvalid %b rdata %h err %b want 1 00A00113 0", i_rvalid, i_rdata, i_err); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_round_robin();
        test_priority();
        test_store();
        test_lock();
        test_timeout();
        test_reset_busy();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
